bounce_box_renderer: RTL and testbench

//  Pixel stage directly downstream of the VGA timing generator. Consumes x/y/active/hsync/vsync
//  and draws a solid box that moves once per frame and bounces off the screen edges.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/bounce_axis.sv | 64 ++++++
 rtl/bounce_box_renderer.sv | 94 +++++++++
 tb/tb_bounce_box_renderer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the box colour palette used by the pixel stages.
package vga_pkg;
    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int RGB_W     = 6;

    localparam logic [RGB_W-1:0] PALETTE [0:7] = '{
        6'b110000, 6'b001100, 6'b000011, 6'b111100,
        6'b110011, 6'b001111, 6'b111111, 6'b100110
    };

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    function automatic logic [RGB_W-1:0] palette_lookup(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction
endpackage

// File: rtl/bounce_axis.sv
// One axis of box motion: position and direction, stepping by SPEED and
// clamping/reversing at 0 and LIMIT. bounce is high in the step cycle that reverses.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 608,
    parameter int SPEED = 2,
    parameter int INIT  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [9:0] pos,
    output logic       bounce
);
    localparam logic [10:0] LIMIT_W = 11'(LIMIT);
    localparam logic [10:0] SPEED_W = 11'(SPEED);

    logic [9:0]  pos_q, pos_d;
    dir_t        dir_q, dir_d;
    logic [10:0] pos_ext;
    logic [10:0] pos_sum;

    assign pos_ext = {1'b0, pos_q};
    assign pos_sum = pos_ext + SPEED_W;

    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        bounce = 1'b0;
        if (step) begin
            if (dir_q == DIR_POS) begin
                if (pos_sum >= LIMIT_W) begin
                    pos_d  = LIMIT_W[9:0];
                    dir_d  = DIR_NEG;
                    bounce = 1'b1;
                end else begin
                    pos_d = pos_sum[9:0];
                end
            end else begin
                // Clamp at 0 so the subtraction below can never underflow.
                if (pos_ext <= SPEED_W) begin
                    pos_d  = 10'd0;
                    dir_d  = DIR_POS;
                    bounce = 1'b1;
                end else begin
                    pos_d = pos_q - SPEED_W[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= 10'(INIT);
            dir_q <= DIR_POS;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos = pos_q;
endmodule

// File: rtl/bounce_box_renderer.sv
// Draws a solid bouncing box over the VGA timing stream; one register stage
// aligns colour with the delayed syncs.
module bounce_box_renderer
    import vga_pkg::*;
#(
    parameter int BOX_W  = 32,
    parameter int BOX_H  = 32,
    parameter int SPEED  = 2,
    parameter int INIT_X = 100,
    parameter int INIT_Y = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       enable,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       corner_pulse,
    output logic [7:0] bounce_count
);
    logic [9:0]  box_x, box_y;
    logic        bounce_x, bounce_y;
    logic        tick, step, hit;
    logic [10:0] box_x_end, box_y_end;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [2:0]       colour_idx_q, colour_idx_d;
    logic [7:0]       bounce_count_q, bounce_count_d;
    logic             corner_q, corner_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;

    // First blanking line start: motion lands outside the visible area.
    assign tick = (x == 10'd0) && (y == 10'(V_DISPLAY));
    assign step = tick && enable;

    bounce_axis #(.LIMIT(H_DISPLAY - BOX_W), .SPEED(SPEED), .INIT(INIT_X)) u_axis_x (
        .clk(clk), .rst(rst), .step(step), .pos(box_x), .bounce(bounce_x)
    );

    bounce_axis #(.LIMIT(V_DISPLAY - BOX_H), .SPEED(SPEED), .INIT(INIT_Y)) u_axis_y (
        .clk(clk), .rst(rst), .step(step), .pos(box_y), .bounce(bounce_y)
    );

    assign box_x_end = {1'b0, box_x} + 11'(BOX_W);
    assign box_y_end = {1'b0, box_y} + 11'(BOX_H);
    assign hit = active && (x >= box_x) && ({1'b0, x} < box_x_end)
                        && (y >= box_y) && ({1'b0, y} < box_y_end);

    always_comb begin
        colour_idx_d   = colour_idx_q;
        bounce_count_d = bounce_count_q;
        corner_d       = bounce_x && bounce_y;
        if (bounce_x || bounce_y) begin
            colour_idx_d   = colour_idx_q + 3'd1;
            bounce_count_d = bounce_count_q + 8'd1;
        end
        rgb_d   = hit ? palette_lookup(colour_idx_q) : '0;
        hsync_d = hsync_in;
        vsync_d = vsync_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q          <= '0;
            colour_idx_q   <= 3'd0;
            bounce_count_q <= 8'd0;
            corner_q       <= 1'b0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
        end else begin
            rgb_q          <= rgb_d;
            colour_idx_q   <= colour_idx_d;
            bounce_count_q <= bounce_count_d;
            corner_q       <= corner_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
        end
    end

    assign r            = rgb_q[5:4];
    assign g            = rgb_q[3:2];
    assign b            = rgb_q[1:0];
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign corner_pulse = corner_q;
    assign bounce_count = bounce_count_q;
endmodule

// File: tb/tb_bounce_box_renderer.sv
// Directed bench: four renderer instances with different geometry share one
// timing stream; an independent motion model supplies expected positions/colours.
module tb_bounce_box_renderer;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       active, hsync_in, vsync_in, enable;

    logic [1:0] r [N];
    logic [1:0] g [N];
    logic [1:0] b [N];
    logic       hsync_out [N];
    logic       vsync_out [N];
    logic       corner_pulse [N];
    logic [7:0] bounce_count [N];

    int total = 0;
    int bad   = 0;

    logic [5:0] pal [0:7] = '{6'b110000, 6'b001100, 6'b000011, 6'b111100,
                              6'b110011, 6'b001111, 6'b111111, 6'b100110};

    int p_bw [N] = '{32, 32, 32, 630};
    int p_bh [N] = '{32, 32, 32, 468};
    int p_sp [N] = '{2, 2, 2, 5};
    int p_ix [N] = '{100, 606, 607, 0};
    int p_iy [N] = '{80, 80, 447, 0};

    int mx [N], my [N], mdx [N], mdy [N], mcol [N], mcnt [N];
    bit mcp [N];

    always #5 clk = ~clk;

    bounce_box_renderer dut0 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .enable(enable), .r(r[0]), .g(g[0]), .b(b[0]),
        .hsync_out(hsync_out[0]), .vsync_out(vsync_out[0]),
        .corner_pulse(corner_pulse[0]), .bounce_count(bounce_count[0]));

    bounce_box_renderer #(.INIT_X(606), .INIT_Y(80)) dut1 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .enable(enable), .r(r[1]), .g(g[1]), .b(b[1]),
        .hsync_out(hsync_out[1]), .vsync_out(vsync_out[1]),
        .corner_pulse(corner_pulse[1]), .bounce_count(bounce_count[1]));

    bounce_box_renderer #(.INIT_X(607), .INIT_Y(447)) dut2 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .enable(enable), .r(r[2]), .g(g[2]), .b(b[2]),
        .hsync_out(hsync_out[2]), .vsync_out(vsync_out[2]),
        .corner_pulse(corner_pulse[2]), .bounce_count(bounce_count[2]));

    bounce_box_renderer #(.BOX_W(630), .BOX_H(468), .SPEED(5), .INIT_X(0), .INIT_Y(0)) dut3 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .enable(enable), .r(r[3]), .g(g[3]), .b(b[3]),
        .hsync_out(hsync_out[3]), .vsync_out(vsync_out[3]),
        .corner_pulse(corner_pulse[3]), .bounce_count(bounce_count[3]));

    function automatic logic [5:0] rgb_of(input int i);
        return {r[i], g[i], b[i]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int xv, input int yv, input logic act,
                         input logic hs, input logic vs);
        x        = 10'(xv);
        y        = 10'(yv);
        active   = act;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(700, 500, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic frame_tick();
        drive(0, 480, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic probe(input int i, input int px, input int py, output logic [5:0] got);
        drive(px, py, 1'b1, 1'b1, 1'b1);
        got = rgb_of(i);
    endtask

    // ---------------- reference model ----------------
    task automatic model_axis(inout int pos, inout int dir, input int lim, input int sp,
                              output bit bnc);
        bnc = 1'b0;
        if (dir == 0) begin
            if (pos + sp >= lim) begin pos = lim; dir = 1; bnc = 1'b1; end
            else pos = pos + sp;
        end else begin
            if (pos <= sp) begin pos = 0; dir = 0; bnc = 1'b1; end
            else pos = pos - sp;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = p_ix[i]; my[i] = p_iy[i]; mdx[i] = 0; mdy[i] = 0;
            mcol[i] = 0; mcnt[i] = 0; mcp[i] = 1'b0;
        end
    endtask

    task automatic model_tick();
        bit bx, by;
        for (int i = 0; i < N; i++) begin
            model_axis(mx[i], mdx[i], 640 - p_bw[i], p_sp[i], bx);
            model_axis(my[i], mdy[i], 480 - p_bh[i], p_sp[i], by);
            if (bx || by) begin
                mcol[i] = (mcol[i] + 1) % 8;
                mcnt[i] = mcnt[i] + 1;
            end
            mcp[i] = bx && by;
        end
    endtask

    // Probes the box edges and their outside neighbours against the model.
    task automatic verify_box(input int i, input string tag);
        logic [5:0] got, col;
        col = pal[mcol[i]];
        probe(i, mx[i], my[i], got);
        total++;
        if (got !== col) begin
            bad++;
            $display("FAIL %s dut%0d top_left (%0d,%0d): got %b want %b", tag, i, mx[i], my[i], got, col);
        end
        probe(i, mx[i] + p_bw[i] - 1, my[i] + p_bh[i] - 1, got);
        total++;
        if (got !== col) begin
            bad++;
            $display("FAIL %s dut%0d bottom_right: got %b want %b", tag, i, got, col);
        end
        if (mx[i] > 0) begin
            probe(i, mx[i] - 1, my[i], got);
            total++;
            if (got !== 6'b0) begin
                bad++;
                $display("FAIL %s dut%0d left_out x=%0d: got %b want 000000", tag, i, mx[i] - 1, got);
            end
        end
        if (mx[i] + p_bw[i] < 640) begin
            probe(i, mx[i] + p_bw[i], my[i], got);
            total++;
            if (got !== 6'b0) begin
                bad++;
                $display("FAIL %s dut%0d right_out x=%0d: got %b want 000000", tag, i, mx[i] + p_bw[i], got);
            end
        end
        if (my[i] > 0) begin
            probe(i, mx[i], my[i] - 1, got);
            total++;
            if (got !== 6'b0) begin
                bad++;
                $display("FAIL %s dut%0d above_out y=%0d: got %b want 000000", tag, i, my[i] - 1, got);
            end
        end
        if (my[i] + p_bh[i] < 480) begin
            probe(i, mx[i], my[i] + p_bh[i], got);
            total++;
            if (got !== 6'b0) begin
                bad++;
                $display("FAIL %s dut%0d below_out y=%0d: got %b want 000000", tag, i, my[i] + p_bh[i], got);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < N; i++) begin
            total++;
            if (rgb_of(i) !== 6'b0 || hsync_out[i] !== 1'b1 || vsync_out[i] !== 1'b1 ||
                corner_pulse[i] !== 1'b0 || bounce_count[i] !== 8'd0) begin
                bad++;
                $display("FAIL %s dut%0d: rgb=%b hs=%b vs=%b cp=%b cnt=%0d want rgb=0 hs=1 vs=1 cp=0 cnt=0",
                         tag, i, rgb_of(i), hsync_out[i], vsync_out[i], corner_pulse[i], bounce_count[i]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        x = 10'd700; y = 10'd500; active = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_pixel();
        logic [5:0] got;
        probe(0, 100, 80, got);
        total++;
        if (got !== 6'b110000) begin bad++; $display("FAIL pix_in (100,80): got %b want 110000", got); end
        probe(0, 132, 80, got);
        total++;
        if (got !== 6'b000000) begin bad++; $display("FAIL pix_out (132,80): got %b want 000000", got); end
        probe(0, 131, 111, got);
        total++;
        if (got !== 6'b110000) begin bad++; $display("FAIL pix_corner (131,111): got %b want 110000", got); end
        probe(0, 100, 112, got);
        total++;
        if (got !== 6'b000000) begin bad++; $display("FAIL pix_below (100,112): got %b want 000000", got); end
        drive(110, 90, 1'b0, 1'b1, 1'b1);
        total++;
        if (rgb_of(0) !== 6'b0) begin bad++; $display("FAIL pix_inactive: got %b want 000000", rgb_of(0)); end

        // Sync toggles must appear exactly one edge later, not before.
        idle();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        #1;
        total++;
        if (hsync_out[0] !== 1'b1 || vsync_out[0] !== 1'b1) begin
            bad++; $display("FAIL sync_early: hs=%b vs=%b want 1 1", hsync_out[0], vsync_out[0]);
        end
        @(posedge clk);
        #1;
        total++;
        if (hsync_out[0] !== 1'b0 || vsync_out[0] !== 1'b0) begin
            bad++; $display("FAIL sync_delay: hs=%b vs=%b want 0 0", hsync_out[0], vsync_out[0]);
        end
        drive(700, 500, 1'b0, 1'b1, 1'b0);
        total++;
        if (hsync_out[0] !== 1'b1 || vsync_out[0] !== 1'b0) begin
            bad++; $display("FAIL sync_independent: hs=%b vs=%b want 1 0", hsync_out[0], vsync_out[0]);
        end
        idle();
    endtask

    task automatic test_first_tick();
        frame_tick();
        model_tick();
        total++;
        if (corner_pulse[2] !== 1'b1) begin bad++; $display("FAIL corner_pulse_set: got %b want 1", corner_pulse[2]); end
        total++;
        if (corner_pulse[1] !== 1'b0) begin bad++; $display("FAIL corner_pulse_single_axis: got %b want 0", corner_pulse[1]); end
        idle();
        total++;
        if (corner_pulse[2] !== 1'b0) begin bad++; $display("FAIL corner_pulse_width: got %b want 0", corner_pulse[2]); end
        total++;
        if (bounce_count[1] !== 8'd1) begin bad++; $display("FAIL edge_count: got %0d want 1", bounce_count[1]); end
        total++;
        if (bounce_count[2] !== 8'd1) begin bad++; $display("FAIL corner_count: got %0d want 1", bounce_count[2]); end
        total++;
        if (bounce_count[0] !== 8'd0) begin bad++; $display("FAIL free_count: got %0d want 0", bounce_count[0]); end
        verify_box(0, "tick1");
        verify_box(1, "tick1");
        verify_box(2, "tick1");
    endtask

    task automatic test_second_tick();
        frame_tick();
        model_tick();
        idle();
        total++;
        if (bounce_count[1] !== 8'd1) begin bad++; $display("FAIL edge_count2: got %0d want 1", bounce_count[1]); end
        verify_box(1, "tick2");
        verify_box(0, "tick2");
    endtask

    task automatic test_enable();
        logic [5:0] got;
        enable = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame_tick();
            idle();
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (bounce_count[i] !== 8'(mcnt[i])) begin
                bad++; $display("FAIL hold_count dut%0d: got %0d want %0d", i, bounce_count[i], mcnt[i]);
            end
            verify_box(i, "hold");
        end
        drive(mx[0] + 2, my[0] + 2, 1'b0, 1'b1, 1'b1);
        total++;
        if (rgb_of(0) !== 6'b0) begin bad++; $display("FAIL hold_inactive: got %b want 000000", rgb_of(0)); end
        probe(0, mx[0] + 2, my[0] + 2, got);
        total++;
        if (got !== pal[mcol[0]]) begin bad++; $display("FAIL hold_render: got %b want %b", got, pal[mcol[0]]); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        drive(mx[0] + 1, my[0] + 1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("reset_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        verify_box(0, "after_reset");
        verify_box(2, "after_reset");
    endtask

    task automatic test_long();
        bit wrap_checked;
        wrap_checked = 1'b0;
        for (int f = 0; f < 2000; f++) begin
            frame_tick();
            model_tick();
            for (int i = 0; i < N; i++) begin
                total++;
                if (bounce_count[i] !== 8'(mcnt[i]) || corner_pulse[i] !== mcp[i]) begin
                    bad++;
                    $display("FAIL long_tick f=%0d dut%0d: cnt=%0d cp=%b want cnt=%0d cp=%b",
                             f, i, bounce_count[i], corner_pulse[i], mcnt[i] % 256, mcp[i]);
                end
            end
            if (mcnt[3] == 256 && !wrap_checked) begin
                wrap_checked = 1'b1;
                total++;
                if (bounce_count[3] !== 8'd0) begin
                    bad++; $display("FAIL count_wrap: got %0d want 0", bounce_count[3]);
                end
            end
            if (f % 16 == 15) begin
                for (int i = 0; i < N; i++) verify_box(i, "long");
            end else begin
                idle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_first_tick();
        test_second_tick();
        test_enable();
        test_reset_mid();
        test_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
